// File: rtl/mul_batch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_batch_pkg
// Purpose  : Shared constants, FSM state encodings and the radix-2 Booth step
//            used by the batch multiply engine and its multiplier core.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mul_batch_pkg;

  // Operand and product widths of the Booth datapath
  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  // Upper half of the Booth register carries one guard bit so that
  // subtracting a -32768 multiplicand cannot overflow.
  localparam int ACC_W  = OP_W + 1;
  // Full Booth working register: {acc, q, q_minus_1}
  localparam int STEP_W = ACC_W + OP_W + 1;

  // Default engine configuration
  localparam int NUM_PAIRS_DEF = 16;
  localparam int OP_BASE_DEF   = 0;
  localparam int PROD_BASE_DEF = 64;
  localparam int ADDR_W_DEF    = 8;

  // Engine FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_MUL   = 3'd2;
  localparam logic [2:0] ST_STORE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // One Booth iteration: look at {q0, q-1}, add or subtract the
  // sign-extended multiplicand into acc, then shift the whole
  // {acc, q, q-1} register right arithmetically by one.
  function automatic logic [STEP_W-1:0] booth_step(
    input logic [STEP_W-1:0] s,
    input logic [OP_W-1:0]   m
  );
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] m_ext;
    m_ext = {m[OP_W-1], m};
    acc   = s[STEP_W-1 -: ACC_W];
    case (s[1:0])
      2'b01:   acc = acc + m_ext;
      2'b10:   acc = acc - m_ext;
      default: acc = acc;
    endcase
    return {acc[ACC_W-1], acc, s[OP_W:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_batch_engine_booth.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul16
// Purpose  : Sequential radix-2 Booth multiplier, signed 16x16 -> 32.
//            One Booth step per cycle; the first step is taken on the same
//            edge that loads the operands, so valid pulses exactly 16 cycles
//            after go.
// Ports    : clk   - clock
//            rst_n - asynchronous active-low reset
//            go    - load a/b and start (restarts an in-flight multiply)
//            a     - signed multiplicand
//            b     - signed multiplier
//            busy  - steps still outstanding
//            valid - one-cycle pulse, p holds the finished product
//            p     - signed product, held until the next go
// Revision : 1.0 - initial release
// ============================================================================
module booth_mul16
  import mul_batch_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  input  logic signed [OP_W-1:0]   a,
  input  logic signed [OP_W-1:0]   b,
  output logic                     busy,
  output logic                     valid,
  output logic signed [PROD_W-1:0] p
);

  localparam int CNT_W = $clog2(OP_W);

  logic [STEP_W-1:0] s_q,     s_d;
  logic [OP_W-1:0]   m_q,     m_d;
  logic [CNT_W-1:0]  step_q,  step_d;
  logic              busy_q,  busy_d;
  logic              valid_q, valid_d;

  always_comb begin
    s_d     = s_q;
    m_d     = m_q;
    step_d  = step_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    if (go) begin
      m_d    = a;
      s_d    = booth_step({{ACC_W{1'b0}}, b, 1'b0}, a);
      step_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      s_d    = booth_step(s_q, m_q);
      step_d = step_q + CNT_W'(1);
      // The go edge already did step 1; this is the 16th and last step.
      if (step_q == CNT_W'(OP_W - 2)) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      m_q     <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      m_q     <= m_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  // Low 32 bits of the 33-bit {acc, q} result
  assign p     = s_q[PROD_W:1];

endmodule
`default_nettype wire

// File: rtl/mul_batch_engine.sv
`default_nettype none
// ============================================================================
// Module   : mul_batch_engine
// Purpose  : Reads NUM_PAIRS pairs of big-endian signed 16-bit operands from
//            byte memory, multiplies each pair with booth_mul16 and writes
//            the 32-bit products back big-endian, then raises done.
//            Each pair takes 4 LOAD + 16 MUL + 4 STORE = 24 cycles.
// Ports    : clk       - clock
//            rst_n     - asynchronous active-low reset
//            start     - high = hold/clear, low = run
//            done      - high once every product has been written
//            mem_addr  - byte address to data memory
//            mem_rdata - combinational read data of mem_addr
//            mem_wdata - write byte
//            mem_we    - write enable (memory writes on rising edge)
// Revision : 1.0 - initial release
// ============================================================================
module mul_batch_engine
  import mul_batch_pkg::*;
#(
  parameter int NUM_PAIRS = NUM_PAIRS_DEF,
  parameter int OP_BASE   = OP_BASE_DEF,
  parameter int PROD_BASE = PROD_BASE_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic              mem_we
);

  localparam int PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

  logic [2:0]        state_q, state_d;
  logic [PAIR_W-1:0] pair_q,  pair_d;
  logic [1:0]        k_q,     k_d;
  logic [7:0]        a_hi_q,  a_hi_d;
  logic [7:0]        a_lo_q,  a_lo_d;
  logic [7:0]        b_hi_q,  b_hi_d;

  logic                     mul_go;
  logic                     mul_busy;
  logic                     mul_valid;
  logic                     mul_done;
  logic signed [PROD_W-1:0] mul_p;
  logic [ADDR_W-1:0]        byte_off;

  // The last operand byte is fed straight from memory on the go cycle, so
  // the multiplier starts on the edge that ends LOAD.
  booth_mul16 u_booth (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (mul_go),
    .a     ({a_hi_q, a_lo_q}),
    .b     ({b_hi_q, mem_rdata}),
    .busy  (mul_busy),
    .valid (mul_valid),
    .p     (mul_p)
  );

  assign mul_done = mul_valid & ~mul_busy;

  // 4*pair + k; address arithmetic wraps at 2^ADDR_W
  assign byte_off = ADDR_W'({pair_q, k_q});

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    k_d     = k_q;
    a_hi_d  = a_hi_q;
    a_lo_d  = a_lo_q;
    b_hi_d  = b_hi_q;
    mul_go  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!start) begin
          state_d = ST_LOAD;
          pair_d  = '0;
          k_d     = '0;
        end
      end
      ST_LOAD: begin
        if (start) begin
          state_d = ST_IDLE;
        end else begin
          case (k_q)
            2'd0:    a_hi_d = mem_rdata;
            2'd1:    a_lo_d = mem_rdata;
            2'd2:    b_hi_d = mem_rdata;
            default: mul_go = 1'b1;
          endcase
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        if (start) begin
          state_d = ST_IDLE;
        end else if (mul_done) begin
          state_d = ST_STORE;
          k_d     = '0;
        end
      end
      ST_STORE: begin
        if (start) begin
          state_d = ST_IDLE;
        end else begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            if (pair_q == PAIR_W'(NUM_PAIRS - 1)) begin
              state_d = ST_DONE;
            end else begin
              pair_d  = pair_q + PAIR_W'(1);
              state_d = ST_LOAD;
            end
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory interface decoded from state so that an async reset clears
  // mem_we/mem_addr/mem_wdata immediately.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state_q)
      ST_LOAD: mem_addr = ADDR_W'(OP_BASE) + byte_off;
      ST_STORE: begin
        mem_addr = ADDR_W'(PROD_BASE) + byte_off;
        mem_we   = 1'b1;
        case (k_q)
          2'd0:    mem_wdata = mul_p[31:24];
          2'd1:    mem_wdata = mul_p[23:16];
          2'd2:    mem_wdata = mul_p[15:8];
          default: mem_wdata = mul_p[7:0];
        endcase
      end
      default: mem_addr = '0;
    endcase
  end

  assign done = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pair_q  <= '0;
      k_q     <= '0;
      a_hi_q  <= '0;
      a_lo_q  <= '0;
      b_hi_q  <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      k_q     <= k_d;
      a_hi_q  <= a_hi_d;
      a_lo_q  <= a_lo_d;
      b_hi_q  <= b_hi_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_batch_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_batch_engine
// Purpose  : Self-checking bench for mul_batch_engine: byte memory model,
//            write monitor, and a reference model computing B*A per pair.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_batch_engine;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_we;

  mul_batch_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory; img is copied in whole while load_img is high
  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic       load_img;
  int         wr_cnt;
  int         bad_cnt;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (load_img) begin
      mem <= img;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      if (mem_addr < 8'd64 || mem_addr > 8'd127) bad_cnt <= bad_cnt + 1;
    end
  end

  // Reference operands and expected products
  logic signed [15:0] a_v  [16];
  logic signed [15:0] b_v  [16];
  logic        [31:0] expw [16];

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int j);
    return {mem[64+4*j], mem[65+4*j], mem[66+4*j], mem[67+4*j]};
  endfunction

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic clear_pairs();
    for (int j = 0; j < 16; j++) begin
      a_v[j] = '0;
      b_v[j] = '0;
    end
  endtask

  task automatic rand_pairs();
    for (int j = 0; j < 16; j++) begin
      a_v[j] = rand16();
      b_v[j] = rand16();
    end
  endtask

  // Builds the memory image and expected products, then loads memory.
  task automatic load_image();
    for (int i = 0; i < 256; i++) img[i] = (i >= 64 && i < 128) ? 8'hEE : 8'h00;
    for (int j = 0; j < 16; j++) begin
      img[4*j]   = a_v[j][15:8];
      img[4*j+1] = a_v[j][7:0];
      img[4*j+2] = b_v[j][15:8];
      img[4*j+3] = b_v[j][7:0];
      expw[j]    = 32'(int'(a_v[j]) * int'(b_v[j]));
    end
    @(negedge clk) load_img = 1'b1;
    @(negedge clk) load_img = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Loads the current pairs and runs to completion; started either by
  // dropping start or by releasing reset with start already low.
  task automatic full_run(input string tag, input bit from_reset);
    int cyc;
    int w0;
    int b0;
    load_image();
    w0 = wr_cnt;
    b0 = bad_cnt;
    if (from_reset) rst_n = 1'b1;
    else            start = 1'b0;
    wait_done(cyc);
    check({tag, "_latency"}, 32'(cyc - 1), 32'd384);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_we_at_done"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_writes"}, 32'(wr_cnt - w0), 32'd64);
    check({tag, "_bad_addr"}, 32'(bad_cnt - b0), 32'd0);
    for (int j = 0; j < 16; j++) begin
      check($sformatf("%s_p%0d", tag, j), word(j), expw[j]);
    end
    start = 1'b1;
    @(negedge clk);
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int  w0;
    int  b0;
    bit  seen_done;
    bit  seen_we;
    n_tests  = 0;
    n_fail   = 0;
    wr_cnt   = 0;
    bad_cnt  = 0;
    load_img = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    // start low during reset must not start a run
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wins_done", {31'd0, done}, 32'd0);
    check("rst_wins_addr", {24'd0, mem_addr}, 32'd0);
    start = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Single nonzero pair
    clear_pairs();
    a_v[0] = 16'sh0003;
    b_v[0] = 16'sh0005;
    full_run("basic", 1'b0);
    check("basic_word0", word(0), 32'h0000000F);

    // Operand extremes
    clear_pairs();
    a_v[0] = 16'sh8000; b_v[0] = 16'sh8000;
    a_v[1] = 16'sh8000; b_v[1] = 16'sh0001;
    a_v[2] = 16'shFFFF; b_v[2] = 16'sh7FFF;
    full_run("corner", 1'b0);
    check("corner_min_min", word(0), 32'h40000000);
    check("corner_min_one", word(1), 32'hFFFF8000);
    check("corner_m1_max", word(2), 32'hFFFF8001);

    // Randomized runs with start toggled between them
    for (int it = 0; it < 10; it++) begin
      rand_pairs();
      full_run($sformatf("rand%0d", it), 1'b0);
    end

    // Abort during MUL of pair 5
    rand_pairs();
    load_image();
    w0 = wr_cnt;
    b0 = bad_cnt;
    start = 1'b0;
    repeat (130) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("abort_we", {31'd0, mem_we}, 32'd0);
    seen_done = 1'b0;
    seen_we   = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done)   seen_done = 1'b1;
      if (mem_we) seen_we   = 1'b1;
    end
    check("abort_done_seen", {31'd0, seen_done}, 32'd0);
    check("abort_we_seen", {31'd0, seen_we}, 32'd0);
    check("abort_writes", 32'(wr_cnt - w0), 32'd20);
    check("abort_bad_addr", 32'(bad_cnt - b0), 32'd0);
    for (int j = 0; j < 16; j++) begin
      check($sformatf("abort_p%0d", j), word(j), (j < 5) ? expw[j] : 32'hEEEEEEEE);
    end
    full_run("after_abort", 1'b0);

    // Reset during STORE of pair 3 (after its first byte is written)
    rand_pairs();
    load_image();
    w0 = wr_cnt;
    start = 1'b0;
    repeat (94) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_done", {31'd0, done}, 32'd0);
    check("rstmid_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    check("rstmid_writes", 32'(wr_cnt - w0), 32'd13);
    for (int j = 0; j < 16; j++) begin
      if (j < 3)       check($sformatf("rstmid_p%0d", j), word(j), expw[j]);
      else if (j == 3) check("rstmid_p3", word(3), {expw[3][31:24], 24'hEEEEEE});
      else             check($sformatf("rstmid_p%0d", j), word(j), 32'hEEEEEEEE);
    end
    full_run("after_reset", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_batch_engine.md
Name: mul_batch_engine

Overview:
- Hardware multiply engine sitting between the top-level start/done handshake and byte-wide data memory.
- After start, reads 16 pairs of 16-bit two's-complement operands from memory and computes each signed 32-bit product with a sequential radix-2 Booth multiplier.
- Writes each product back big-endian, then raises done.
- Produces exactly the memory image the program-3 bench checks, so it serves as a hardware reference for that test.

Parameters:
- NUM_PAIRS, 16, operand pairs per run
- OP_BASE, 0, byte address of first operand
- PROD_BASE, 64, byte address of first product
- ADDR_W, 8, data-memory address width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; high = hold/clear, low = run
- done  output  1  acknowledge; high when all products written
- mem_addr  output  ADDR_W  byte address to data memory
- mem_rdata  input  8  data-memory read byte, combinational read of mem_addr
- mem_wdata  output  8  write byte
- mem_we  output  1  write enable, memory writes on rising edge

Behaviour:
- Reset (rst_n low, async): state=IDLE, done=0, mem_we=0, mem_addr=0, mem_wdata=0, pair counter=0, accumulator=0. Reset mid-run abandons the run; no further writes occur.
- Operand layout for pair j:
  - A = {mem[OP_BASE+4j], mem[OP_BASE+4j+1]}
  - B = {mem[OP_BASE+4j+2], mem[OP_BASE+4j+3]}
  - P = B*A, signed, full 32 bits, no saturation.
  - P bytes go to PROD_BASE+4j .. +4j+3, MSB first.
- IDLE: done=0. On a rising edge with start=0, go to LOAD with pair=0.
- LOAD: 4 cycles. mem_addr = OP_BASE+4*pair+k for k=0..3; each byte is captured at the edge ending its cycle.
- MUL: 16 cycles via booth_mul16; one Booth step per cycle (examine {q0,q-1}, add/sub/none, arithmetic shift right).
- STORE: 4 cycles. mem_addr = PROD_BASE+4*pair+k, mem_we=1, mem_wdata = P[31-8k -: 8].
- After the 4th store:
  - if pair==NUM_PAIRS-1, go to DONE;
  - else pair++ and go to LOAD.
- Per-pair latency: exactly 24 cycles.
- done rises at the edge ending the final STORE cycle, i.e. 24*NUM_PAIRS = 384 cycles after LOAD is entered.
- DONE: done=1 and mem_we=0, held while start=0. On the first edge with start=1, go to IDLE; done drops at that edge.
- start=1 while in LOAD/MUL/STORE aborts to IDLE at the next edge:
  - mem_we drops at that edge, so a partially written product may remain;
  - done stays 0.
- start low in IDLE while rst_n is low: reset wins.
- mem_we is 0 in every state except STORE.
- Addresses are computed modulo 2^ADDR_W (wrap, no error).
- Corner cases that must be exact:
  - -32768 * -32768 = 0x40000000.
  - -32768 * 1 = 0xFFFF8000.
  - The Booth accumulator is 33 bits internally so the -32768 multiplicand does not overflow. The result is the low 32 bits.

Decomposition:
- Package mul_batch_pkg holds:
  - state enum {IDLE, LOAD, MUL, STORE, DONE}
  - Booth step width constants (OP_W=16, PROD_W=32)
  - default base-address localparams
- Sub-module booth_mul16 handles the multiply itself.
  - Inputs: clk, rst_n, go, signed [15:0] a, signed [15:0] b.
  - Outputs: busy, valid (1-cycle pulse), signed [31:0] p.
  - Fixed latency: 16 cycles from go to valid.
- Top FSM, address generation and byte sequencing stay in mul_batch_engine.

Test Plan:
- Preload pair 0: A=0x0003, B=0x0005 (bytes 00 03 00 05); other pairs zero. Drop start -> mem[64..67]=00 00 00 0F; all other products 0; done high exactly 384 cycles after LOAD entry.
- Pair 0: A=0x8000, B=0x8000 -> 40 00 00 00. Pair 1: A=0x8000, B=0x0001 -> FF FF 80 00. Pair 2: A=0xFFFF, B=0x7FFF -> FF FF 80 01.
- Run 16 random signed pairs, 10 iterations with start toggled high then low between runs -> all 16 products match B*A each run. done drops on the edge after start goes high.
- Raise start mid-MUL of pair 5 -> IDLE next edge, mem_we=0 thereafter, done stays 0, mem[84..] unchanged. A later start-low run completes correctly.
- Assert rst_n low during STORE of pair 3 -> done=0, mem_we=0 immediately (async). After release with start=0, a full run completes correctly.
- Monitor mem_we -> high only on PROD_BASE..PROD_BASE+63, exactly 64 write cycles per run, never on operand addresses.
